vector_mem_sequencer: RTL and testbench

VECTOR_MEM_SEQUENCER -- requirements
Module: vector_mem_sequencer

---
 rtl/vector_mem_sequencer_pkg.sv | 19 +
 rtl/vector_mem_sequencer_if.sv | 43 ++++
 rtl/vector_mem_sequencer.sv | 97 +++++++++
 tb/tb_vector_mem_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_mem_sequencer_pkg.sv
// Shared types for the vector memory sequencer and the vector load/store unit.
package vec_mem_pkg;

  localparam int LANES  = 4;
  localparam int DATA_W = 32;

  // One 32-bit word per lane; element [0] is lane 0.
  typedef logic [0:LANES-1][DATA_W-1:0] lane_vec_t;

  // Sequencer phases: wait for request, issue four lane accesses,
  // catch the last read word, hold the response.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/vector_mem_sequencer_if.sv
// Request, response and memory-port bundle for the vector memory sequencer.
//
// Handshake rules: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where
// resp_valid and resp_ready are both 1. Once resp_valid is 1, resp_valid and
// resp_rdata hold until that transfer. The memory port has no handshake:
// mem_en strobes one access per cycle and read data returns on mem_rdata
// exactly one cycle after a read strobe.
interface vector_mem_sequencer_if
  import vec_mem_pkg::*;
#(
  parameter int MEM_ADDR_W = 10
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [31:0]           req_base;
  lane_vec_t             req_wdata;

  logic                  resp_valid;
  logic                  resp_ready;
  lane_vec_t             resp_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  // Requester plus memory side.
  modport master (
    output req_valid, req_we, req_base, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_we, req_base, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/vector_mem_sequencer.sv
// Vector memory sequencer: turns one 4-lane load/store request into four
// consecutive single-word memory accesses and returns one vector response.
module vector_mem_sequencer
  import vec_mem_pkg::*;
#(
  parameter int MEM_ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vector_mem_sequencer_if.slave   bus,
  output state_t                  state_dbg
);

  state_t    state;
  logic [1:0] lane;
  logic      we_q;
  logic [31:0] base_q;
  lane_vec_t wdata_q;

  // Address and store data follow the lane counter; with reset values of
  // zero they also read zero while in reset. Wrap past all-ones is silent.
  assign bus.mem_addr  = MEM_ADDR_W'(base_q + 32'(lane));
  assign bus.mem_wdata = wdata_q[lane];
  assign state_dbg     = state;

  // Sequencer FSM with registered handshake, strobe and gather outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      lane           <= 2'd0;
      we_q           <= 1'b0;
      base_q         <= 32'd0;
      wdata_q        <= '0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            // Snapshot the whole request so later req_* changes are ignored.
            we_q           <= bus.req_we;
            base_q         <= bus.req_base;
            wdata_q        <= bus.req_wdata;
            lane           <= 2'd0;
            bus.req_ready  <= 1'b0;
            bus.resp_rdata <= '0;
            bus.mem_en     <= 1'b1;
            bus.mem_we     <= bus.req_we;
            state          <= ISSUE;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end

        ISSUE: begin
          // Read data for the previous lane arrives one cycle after its strobe.
          if (!we_q && (lane != 2'd0)) begin
            bus.resp_rdata[lane - 2'd1] <= bus.mem_rdata;
          end
          if (lane == 2'd3) begin
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            if (we_q) begin
              bus.resp_valid <= 1'b1;
              state          <= RESP;
            end else begin
              state <= DRAIN;
            end
          end else begin
            lane <= lane + 2'd1;
          end
        end

        DRAIN: begin
          bus.resp_rdata[3] <= bus.mem_rdata;
          bus.resp_valid    <= 1'b1;
          state             <= RESP;
        end

        RESP: begin
          // Ready comes back one cycle after the response is taken.
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Scoreboard bench for vector_mem_sequencer with a word-array memory model.
module tb_vector_mem_sequencer;
  import vec_mem_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } acc_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_mem_sequencer_if #(.MEM_ADDR_W(AW)) bus ();
  state_t state_dbg;

  vector_mem_sequencer #(.MEM_ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  // ---------------- scoreboard state ----------------
  logic [127:0] exp_q[$];
  int           due_q[$];
  acc_t         acc_q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  last_consume = -100;
  int  stall_len = 0;
  int  wait_cnt = 0;
  bit  prev_valid = 1'b0;
  acc_t mon_a;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: what a request must do, from the access rules alone.
  task automatic model(input logic we, input logic [31:0] base, input lane_vec_t wd, input int c0);
    lane_vec_t     e;
    logic [AW-1:0] a;
    e = '0;
    for (int i = 0; i < LANES; i++) begin
      a = AW'((base + 32'(i)) % DEPTH);
      acc_q.push_back('{we: we, addr: a, wdata: (we ? wd[i] : 32'h0)});
      if (we) ref_mem[a] = wd[i];
      else    e[i] = ref_mem[a];
    end
    exp_q.push_back(e);
    due_q.push_back(c0 + (we ? 5 : 6));
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_en) begin
        if (acc_q.size() == 0) begin
          chk("mem_en_unexpected", 128'(bus.mem_en), 128'(0));
        end else begin
          mon_a = acc_q.pop_front();
          chk("mem_we", 128'(bus.mem_we), 128'(mon_a.we));
          chk("mem_addr", 128'(bus.mem_addr), 128'(mon_a.addr));
          if (mon_a.we) chk("mem_wdata", 128'(bus.mem_wdata), 128'(mon_a.wdata));
        end
      end
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 128'(bus.resp_valid), 128'(0));
        end else begin
          chk("resp_rdata", bus.resp_rdata, exp_q[0]);
          if (!prev_valid) chk("resp_latency", 128'(cyc), 128'(due_q[0]));
        end
        chk("resp_idle_ready_mem", {126'd0, bus.req_ready, bus.mem_en}, 128'd0);
      end
      prev_valid = bus.resp_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst_n && bus.resp_valid && bus.resp_ready && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
      last_consume = cyc;
    end
  end

  // Response consumer: stalls stall_len valid cycles, then takes it.
  initial begin
    bus.resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.resp_valid) begin
        if (wait_cnt < stall_len) begin
          bus.resp_ready = 1'b0;
          wait_cnt++;
        end else begin
          bus.resp_ready = 1'b1;
        end
      end else begin
        wait_cnt = 0;
        bus.resp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic we, input logic [31:0] base, input lane_vec_t wd, input bit b2b);
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_base  = base;
    bus.req_wdata = wd;
    while (!acc && t < 200) begin
      @(posedge clk);
      if (bus.req_ready) acc = 1'b1;
      t++;
    end
    if (!acc) begin
      chk("accept_timeout", 128'(acc), 128'(1));
      bus.req_valid = 1'b0;
      return;
    end
    if (b2b) chk("b2b_accept_cycle", 128'(cyc), 128'(last_consume + 1));
    model(we, base, wd, cyc);
    #1;
  endtask

  task automatic release_and_scramble();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom_range(0, 1));
    bus.req_base  = $urandom;
    for (int i = 0; i < LANES; i++) bus.req_wdata[i] = $urandom;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || acc_q.size() != 0) && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0 || acc_q.size() != 0)
      chk("drain_timeout", 128'(exp_q.size() + acc_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  function automatic lane_vec_t rand_vec();
    lane_vec_t v;
    for (int i = 0; i < LANES; i++) v[i] = $urandom;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    lane_vec_t     wd;
    logic [31:0]   old2, old3;
    logic [31:0]   base;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_base  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end

    // Reset values.
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {122'd0, bus.req_ready, bus.resp_valid, bus.mem_en, bus.mem_we, 2'(state_dbg)}, 128'd0);
    chk("reset_rdata", bus.resp_rdata, 128'd0);
    chk("reset_addr_wdata", {86'd0, bus.mem_addr, bus.mem_wdata}, 128'd0);
    rst_n = 1'b1;
    #1 chk("ready_before_first_edge", 128'(bus.req_ready), 128'(0));
    @(negedge clk);
    chk("ready_after_release", 128'(bus.req_ready), 128'(1));

    // Store base 0x10.
    stall_len = 0;
    wd = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
    send(1'b1, 32'h10, wd, 1'b0);
    release_and_scramble();
    wait_drain();
    chk("store_mem_0x13", 128'(mem[10'h13]), 128'(32'hA3));

    // Load base 0x20 from preloaded words.
    mem[10'h20] = 32'd11; mem[10'h21] = 32'd22; mem[10'h22] = 32'd33; mem[10'h23] = 32'd44;
    ref_mem[10'h20] = 32'd11; ref_mem[10'h21] = 32'd22; ref_mem[10'h22] = 32'd33; ref_mem[10'h23] = 32'd44;
    send(1'b0, 32'h20, rand_vec(), 1'b0);
    release_and_scramble();
    wait_drain();

    // Load across the top of the address space.
    send(1'b0, 32'h3FE, rand_vec(), 1'b0);
    release_and_scramble();
    wait_drain();

    // Response held for five cycles.
    stall_len = 5;
    send(1'b0, 32'h100, rand_vec(), 1'b0);
    release_and_scramble();
    wait_drain();
    stall_len = 0;

    // Reset in cycle 3 of a store.
    old2 = ref_mem[10'h42];
    old3 = ref_mem[10'h43];
    wd = rand_vec();
    send(1'b1, 32'h40, wd, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("abort_mem_en", 128'(bus.mem_en), 128'(0));
    chk("abort_resp_valid", 128'(bus.resp_valid), 128'(0));
    acc_q.delete();
    exp_q.delete();
    due_q.delete();
    ref_mem[10'h42] = old2;
    ref_mem[10'h43] = old3;
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_ready_in_reset", 128'(bus.req_ready), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", 128'(bus.req_ready), 128'(1));
    repeat (8) @(negedge clk);
    chk("abort_lane0", 128'(mem[10'h40]), 128'(wd[0]));
    chk("abort_lane1", 128'(mem[10'h41]), 128'(wd[1]));
    chk("abort_lane2", 128'(mem[10'h42]), 128'(old2));
    chk("abort_lane3", 128'(mem[10'h43]), 128'(old3));
    send(1'b0, 32'h40, rand_vec(), 1'b0);
    release_and_scramble();
    wait_drain();

    // Back-to-back store then load, valid held high.
    stall_len = 1;
    send(1'b1, 32'h80, rand_vec(), 1'b0);
    send(1'b0, 32'h80, rand_vec(), 1'b1);
    release_and_scramble();
    wait_drain();

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      stall_len = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) base = {$urandom_range(0, 65535), 6'd0, 10'h3FC} + 32'($urandom_range(0, 3));
      else base = $urandom;
      send(1'($urandom_range(0, 1)), base, rand_vec(), 1'b0);
      release_and_scramble();
      wait_drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
